// File: rtl/sn74121_oneshot.sv
// SN74121-class monostable for the PDP-8/I timing chain: edge-detects the A/B trigger
// inputs and emits one WIDTH-cycle pulse on q/q_n. Define SN74121_RETRIGGER_EN for 74122-style retriggering.
module sn74121_oneshot #(
  parameter int WIDTH    = 8,
  parameter int RECOVERY = 2,
  localparam int MAXV    = (WIDTH > RECOVERY) ? WIDTH : RECOVERY,
  localparam int CW      = $clog2(MAXV + 1)
) (
  input  logic mclk,
  input  logic reset,
  input  logic a1_n,
  input  logic a2_n,
  input  logic b,
  input  logic clr_n,
  output logic q,
  output logic q_n,
  output logic busy
);

  // Handshake: none; triggers are level samples, and q/q_n/busy are plain registered levels.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PULSE   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  localparam logic [CW-1:0] W_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] R_LOAD = (RECOVERY > 0) ? CW'(RECOVERY - 1) : '0;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          a1_r, a2_r, b_r, clr_r;
  logic          t_prev, armed;
  logic          t, trg;
  logic          q_nxt, busy_nxt;

  assign t   = (~a1_r | ~a2_r) & b_r;
  assign trg = t & ~t_prev & clr_r;

  always_ff @(posedge mclk) begin
    if (reset) begin
      a1_r   <= 1'b1;
      a2_r   <= 1'b1;
      b_r    <= 1'b0;
      clr_r  <= 1'b1;
      t_prev <= 1'b1;
      armed  <= 1'b0;
      state  <= S_IDLE;
      cnt    <= '0;
      q      <= 1'b0;
      q_n    <= 1'b1;
      busy   <= 1'b0;
    end else begin
      a1_r   <= a1_n;
      a2_r   <= a2_n;
      b_r    <= b;
      clr_r  <= clr_n;
      // The first sample after reset sees its predecessor as asserted, so a level held across release never fires.
      t_prev <= t | ~armed;
      armed  <= 1'b1;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      q      <= q_nxt;
      q_n    <= ~q_nxt;
      busy   <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!clr_r) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trg) begin
            state_nxt = S_PULSE;
            cnt_nxt   = W_LOAD;
          end
        end
        S_PULSE: begin
`ifdef SN74121_RETRIGGER_EN
          if (trg) begin
            cnt_nxt = W_LOAD;
          end else
`endif
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else if (RECOVERY > 0) begin
            state_nxt = S_RECOVER;
            cnt_nxt   = R_LOAD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_RECOVER: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    q_nxt    = (state_nxt == S_PULSE);
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: doc/sn74121_oneshot.md
Name: sn74121_oneshot

Overview:
- Synchronous model of an SN74121-class monostable, one unit, for the PDP-8/I timing chain.
- Detects trigger edges on oversampled TTL-level inputs and emits one fixed-width pulse, counted in mclk cycles.
- Sits directly upstream of the JK flip-flop models: its q/q_n outputs drive their clk_n inputs, like the RC one-shots in the original pulse logic.

Parameters:
- WIDTH, 8, output pulse width in mclk cycles; must be >= 1.
- RECOVERY, 2, dead time after the pulse ends, in mclk cycles, during which triggers are ignored; >= 0.
- CW, $clog2(max(WIDTH,RECOVERY)+1), counter width; derived, not overridden.

Ports:
- mclk  input  1  master clock; only clock in the block.
- reset  input  1  synchronous, active-high reset.
- a1_n  input  1  active-low trigger input A1.
- a2_n  input  1  active-low trigger input A2.
- b  input  1  active-high trigger input B (Schmitt input in the TTL part).
- clr_n  input  1  active-low clear, sampled.
- q  output  1  pulse output, active high.
- q_n  output  1  complement of q.
- busy  output  1  high while the state is PULSE or RECOVER.

Behaviour:
- One clock (mclk); reset is synchronous and active-high.
- Input sampling:
  - a1_n, a2_n, b and clr_n are each registered once (a1_r, a2_r, b_r, clr_r).
  - Trigger level t = (!a1_r | !a2_r) & b_r.
  - t_prev <= t every cycle.
  - Trigger event trg = t & !t_prev & clr_r.
  - This covers both A falling while B is high and B rising while either A is low.
  - B rising while both A are high gives no trigger.
- Latency: an input change sampled at edge k is detected during cycle k; q rises at edge k+1.
- States:
  - IDLE: q=0. On trg, go to PULSE with cnt=WIDTH-1 and q=1.
  - PULSE: q=1.
    - cnt>0: decrement.
    - cnt==0: q=0. Go to RECOVER with cnt=RECOVERY-1 if RECOVERY>0, else go to IDLE.
    - q is therefore high for exactly WIDTH cycles.
  - RECOVER: q=0.
    - cnt>0: decrement.
    - cnt==0: go to IDLE.
    - Exactly RECOVERY cycles are spent in RECOVER.
- Trigger acceptance:
  - trg is accepted only if the state is IDLE in the cycle it is detected.
  - In PULSE or RECOVER, trg is discarded: it is neither queued nor remembered.
- q_n is always the exact complement of q; both are registered, with no combinational path from inputs.
- busy is registered and equals (state != IDLE).
- Clear:
  - While clr_r==0, the next edge forces IDLE with q=0, q_n=1 and cnt=0.
  - The pulse is truncated with no recovery period.
  - No trigger is accepted while clr_r==0.
  - clr_n rising does not generate a trigger.
- Reset (any state, including mid-pulse):
  - q=0, q_n=1, busy=0, state=IDLE, cnt=0.
  - Sample registers a1_r=1, a2_r=1, b_r=0, clr_r=1.
  - t_prev=1, so a trigger level already asserted across reset release does not fire.
  - Reset has priority over clear and trigger.
- Simultaneous events:
  - PULSE ending (cnt==0) in the same cycle as trg: the pulse ends normally and trg is dropped. Also applies when RECOVERY=0.
  - RECOVER finishing in the same cycle as trg: trg is dropped. It must be detected in IDLE.

Optional Feature:
- Macro: SN74121_RETRIGGER_EN.
- Defined (74122-style retriggerable behaviour):
  - trg accepted while in PULSE reloads cnt=WIDTH-1 and keeps q=1, with no glitch low.
  - This includes the cnt==0 cycle, so q stays high and the pulse is extended.
  - trg in RECOVER is still dropped.
- Not defined: non-retriggerable exactly as in Behaviour.
- Clear, reset and latency are identical in both builds.

Test Plan (WIDTH=5, RECOVERY=2):
- Basic pulse:
  - Stimulus: reset 3 cycles; b=1, a2_n=1; drop a1_n so it is sampled at edge 10.
  - Required: q=1 and busy=1 at edge 11; q=0 at edge 16; q_n complementary throughout; busy=0 at edge 18.
- Ignored/retriggered edge:
  - Stimulus: from the basic pulse, raise a1_n then drop it again so it is sampled at edge 13.
  - Required without the macro: q still falls at edge 16.
  - Required with SN74121_RETRIGGER_EN: q stays high and falls at edge 19.
- Recovery window:
  - Stimulus: trigger detected in the cycle after edge 17.
  - Required: ignored, no pulse.
  - Stimulus: re-trigger detected after edge 18.
  - Required: q=1 at edge 19 for 5 cycles.
- Trigger gating:
  - Stimulus: a1_n=0 held, b rises.
  - Required: one 5-cycle pulse.
  - Stimulus: both A inputs high, b rises.
  - Required: no pulse. Also, b falling never triggers.
- Clear and reset mid-pulse:
  - Stimulus: clr_n low sampled at pulse cycle 2.
  - Required: q=0 and busy=0 next edge, new trigger accepted immediately after clr_n returns high (no recovery period).
  - Stimulus: reset asserted at pulse cycle 3.
  - Required: q=0 at that edge.
- Reset release with trigger level high:
  - Stimulus: hold b=1, a1_n=0 through reset and after release.
  - Required: no pulse.
  - Stimulus: a1_n toggled high then low.
  - Required: exactly one pulse.
